// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor and the shader pipeline that drives it:
// opcodes, fixed-point constants, FSM encoding and lane helpers.
package vp_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;

  localparam logic [LANE_W-1:0] FP_ONE    = 16'h0100;
  localparam int                FRAC_BITS = $clog2(FP_ONE);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DOT    = 4'd3;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_LANE,
    ST_SQRT,
    ST_FINISH
  } vp_state_e;

  function automatic logic [LANE_W-1:0] lane_get(input logic [LANE_W*NUM_LANES-1:0] v,
                                                 input logic [1:0] idx);
    return v[idx*LANE_W +: LANE_W];
  endfunction

  // Ops that finish in the single EXEC cycle; illegal opcodes take this path too.
  function automatic logic op_is_single(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op > OP_LENGTH);
  endfunction

endpackage

// File: rtl/vp_if.sv
// Shader-to-vector-processor request/response bundle.
interface vp_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4
);
  logic                               start;
  logic [3:0]                         operation;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vec_a;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vec_b;
  logic [DATA_WIDTH-1:0]              scalar;
  logic                               busy;
  logic                               done;
  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] result;
  logic                               result_valid;

  modport master (
    output start, operation, vec_a, vec_b, scalar,
    input  busy, done, result, result_valid
  );

  modport slave (
    input  start, operation, vec_a, vec_b, scalar,
    output busy, done, result, result_valid
  );
endinterface

// File: rtl/vp_isqrt.sv
// Restoring bit-serial integer square root: one root bit per cycle, the first
// bit resolved on the start edge itself so the root is ready ITERS cycles later.
module vp_isqrt #(
  parameter int ITERS = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [2*ITERS-1:0] i_radicand,
  output logic               o_done,
  output logic [ITERS-1:0]   o_root
);

  localparam int RAD_W = 2 * ITERS;
  localparam int REM_W = ITERS + 3;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [RAD_W-1:0] r_rad;
  logic [REM_W-1:0] r_rem;
  logic [ITERS-1:0] r_root;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [RAD_W-1:0] w_rad_cur;
  logic [REM_W-1:0] w_rem_cur;
  logic [REM_W-1:0] w_shift;
  logic [REM_W-1:0] w_trial;
  logic [REM_W-1:0] w_rem_nx;
  logic [ITERS-1:0] w_root_cur;
  logic [ITERS-1:0] w_root_nx;
  logic             w_step;

  assign w_step = i_start | (r_cnt != '0);

  always_comb begin
    w_rad_cur  = i_start ? i_radicand : r_rad;
    w_rem_cur  = i_start ? '0 : r_rem;
    w_root_cur = i_start ? '0 : r_root;
    w_shift    = (w_rem_cur << 2) | REM_W'(w_rad_cur[RAD_W-1 -: 2]);
    w_trial    = {1'b0, w_root_cur, 2'b01};
    if (w_shift >= w_trial) begin
      w_rem_nx  = w_shift - w_trial;
      w_root_nx = (w_root_cur << 1) | ITERS'(1);
    end else begin
      w_rem_nx  = w_shift;
      w_root_nx = w_root_cur << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= !i_start && (r_cnt == CNT_W'(1));
      if (i_start) begin
        r_cnt <= CNT_W'(ITERS - 1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_step) begin
      r_rem  <= w_rem_nx;
      r_root <= w_root_nx;
      r_rad  <= w_rad_cur << 2;
    end
  end

  assign o_done = r_done;
  assign o_root = r_root;

endmodule

// File: rtl/vector_processor.sv
// 4-lane 8.8 fixed-point vector engine: one shared 17x17 signed multiplier walked
// across the lanes, plus a bit-serial square root for LENGTH.
module vector_processor
  import vp_pkg::*;
#(
  parameter int DATA_WIDTH   = LANE_W,
  parameter int VECTOR_WIDTH = NUM_LANES,
  parameter int SQRT_ITERS   = 17
) (
  input logic  clk,
  input logic  rst_n,
  vp_if.slave  bus
);

  localparam int VEC_W = DATA_WIDTH * VECTOR_WIDTH;
  localparam int MUL_W = DATA_WIDTH + 1;
  localparam int ACC_W = 2 * MUL_W;
  localparam int IDX_W = $clog2(VECTOR_WIDTH);

  vp_state_e r_state;
  vp_state_e w_next;
  vp_state_e w_go;

  logic                  r_busy;
  logic                  r_done;
  logic [VEC_W-1:0]      r_result;
  logic [3:0]            r_op;
  logic [VEC_W-1:0]      r_a;
  logic [VEC_W-1:0]      r_b;
  logic [DATA_WIDTH-1:0] r_scalar;
  logic [IDX_W-1:0]      r_lane;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_work [VECTOR_WIDTH];

  logic                    w_accept;
  logic                    w_last_lane;
  logic [DATA_WIDTH-1:0]   w_a_lane;
  logic [DATA_WIDTH-1:0]   w_b_lane;
  logic signed [MUL_W-1:0] w_mul_a;
  logic signed [MUL_W-1:0] w_mul_b;
  logic signed [ACC_W-1:0] w_mul_a_x;
  logic signed [ACC_W-1:0] w_mul_b_x;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_nx;
  logic [DATA_WIDTH-1:0]   w_lane_u;
  logic [VEC_W-1:0]        w_final;
  logic                    w_sqrt_start;
  logic                    w_sqrt_done;
  logic [SQRT_ITERS-1:0]   w_root;

  function automatic logic [DATA_WIDTH-1:0] sat_u(input logic signed [ACC_W-1:0] p);
    logic signed [ACC_W-1:0] s;
    s = p >>> FRAC_BITS;
    return (|s[ACC_W-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_s(input logic signed [ACC_W-1:0] p);
    logic signed [ACC_W-1:0]    s;
    logic [ACC_W-DATA_WIDTH:0]  hi;
    s  = p >>> FRAC_BITS;
    hi = s[ACC_W-1:DATA_WIDTH-1];
    if ((&hi) || !(|hi)) return s[DATA_WIDTH-1:0];
    return s[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_root(input logic [SQRT_ITERS-1:0] r);
    return (|r[SQRT_ITERS-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : r[DATA_WIDTH-1:0];
  endfunction

  assign w_accept    = bus.start & ~r_busy;
  assign w_go        = op_is_single(bus.operation) ? ST_EXEC : ST_LANE;
  assign w_last_lane = (r_lane == IDX_W'(VECTOR_WIDTH - 1));
  assign w_a_lane    = r_a[r_lane*DATA_WIDTH +: DATA_WIDTH];
  assign w_b_lane    = r_b[r_lane*DATA_WIDTH +: DATA_WIDTH];

  // Unsigned ops zero-extend into the signed multiplier, signed ops sign-extend.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_op)
      OP_MUL: begin
        w_mul_a = {1'b0, w_a_lane};
        w_mul_b = {1'b0, w_b_lane};
      end
      OP_SCALE: begin
        w_mul_a = {1'b0, w_a_lane};
        w_mul_b = {1'b0, r_scalar};
      end
      OP_DOT: begin
        w_mul_a = {w_a_lane[DATA_WIDTH-1], w_a_lane};
        w_mul_b = {w_b_lane[DATA_WIDTH-1], w_b_lane};
      end
      OP_LENGTH: begin
        w_mul_a = {w_a_lane[DATA_WIDTH-1], w_a_lane};
        w_mul_b = {w_a_lane[DATA_WIDTH-1], w_a_lane};
      end
      default: ;
    endcase
  end

  assign w_mul_a_x = {{(ACC_W-MUL_W){w_mul_a[MUL_W-1]}}, w_mul_a};
  assign w_mul_b_x = {{(ACC_W-MUL_W){w_mul_b[MUL_W-1]}}, w_mul_b};
  assign w_prod    = w_mul_a_x * w_mul_b_x;
  assign w_acc_nx  = r_acc + w_prod;
  assign w_lane_u  = sat_u(w_prod);

  // Final value is formed on the edge that enters FINISH, so the last lane comes straight from the multiplier.
  always_comb begin
    w_final = '0;
    case (r_op)
      OP_ADD: begin
        for (int i = 0; i < VECTOR_WIDTH; i++)
          w_final[i*DATA_WIDTH +: DATA_WIDTH] = r_a[i*DATA_WIDTH +: DATA_WIDTH] + r_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_SUB: begin
        for (int i = 0; i < VECTOR_WIDTH; i++)
          w_final[i*DATA_WIDTH +: DATA_WIDTH] = r_a[i*DATA_WIDTH +: DATA_WIDTH] - r_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
      OP_MUL, OP_SCALE: begin
        for (int i = 0; i < VECTOR_WIDTH - 1; i++)
          w_final[i*DATA_WIDTH +: DATA_WIDTH] = r_work[i];
        w_final[VEC_W-1 -: DATA_WIDTH] = w_lane_u;
      end
      OP_DOT:    w_final[VEC_W-1 -: DATA_WIDTH] = sat_s(w_acc_nx);
      OP_LENGTH: w_final[VEC_W-1 -: DATA_WIDTH] = sat_root(w_root);
      default:   w_final = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_go;
      ST_EXEC:   w_next = ST_FINISH;
      ST_LANE:   if (w_last_lane) w_next = (r_op == OP_LENGTH) ? ST_SQRT : ST_FINISH;
      ST_SQRT:   if (w_sqrt_done) w_next = ST_FINISH;
      ST_FINISH: w_next = w_accept ? w_go : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_lane   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_EXEC) || (w_next == ST_LANE) || (w_next == ST_SQRT);
      r_done  <= (w_next == ST_FINISH);
      r_lane  <= (r_state == ST_LANE) ? r_lane + IDX_W'(1) : '0;
      if (w_next == ST_FINISH) r_result <= w_final;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op     <= bus.operation;
      r_a      <= bus.vec_a;
      r_b      <= bus.vec_b;
      r_scalar <= bus.scalar;
      r_acc    <= '0;
    end else if (r_state == ST_LANE) begin
      r_acc          <= w_acc_nx;
      r_work[r_lane] <= w_lane_u;
    end
  end

  assign w_sqrt_start = (r_state == ST_LANE) && w_last_lane && (r_op == OP_LENGTH);

  vp_isqrt #(
    .ITERS (SQRT_ITERS)
  ) u_isqrt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_sqrt_start),
    .i_radicand ($unsigned(w_acc_nx)),
    .o_done     (w_sqrt_done),
    .o_root     (w_root)
  );

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_done;
  assign bus.result       = r_result;

endmodule

// File: tb/tb_vector_processor.sv
// Bench for vector_processor: directed table, handshake/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_vector_processor;
  import vp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  vp_if #(.DATA_WIDTH(16), .VECTOR_WIDTH(4)) bus();

  vector_processor #(.DATA_WIDTH(16), .VECTOR_WIDTH(4), .SQRT_ITERS(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] s;
    logic [63:0] exp;
    logic [7:0]  busy;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic longint isqrt_ref(input longint v);
    longint r;
    r = longint'($sqrt(real'(v)));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [15:0] s);
    logic [63:0] r;
    longint acc, p, ua, ub, sa, sb, us;
    r = '0;
    acc = 0;
    us = longint'(s);
    for (int i = 0; i < 4; i++) begin
      ua = longint'(lane_get(a, 2'(i)));
      ub = longint'(lane_get(b, 2'(i)));
      sa = longint'($signed(lane_get(a, 2'(i))));
      sb = longint'($signed(lane_get(b, 2'(i))));
      case (op)
        4'd0: r[i*16 +: 16] = 16'(ua + ub);
        4'd1: r[i*16 +: 16] = 16'(ua - ub);
        4'd2: begin p = (ua * ub) / 256; r[i*16 +: 16] = (p > 65535) ? 16'hFFFF : 16'(p); end
        4'd4: begin p = (ua * us) / 256; r[i*16 +: 16] = (p > 65535) ? 16'hFFFF : 16'(p); end
        4'd3: acc += sa * sb;
        4'd5: acc += sa * sa;
        default: ;
      endcase
    end
    if (op == 4'd3) begin
      p = acc >>> 8;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      r[63:48] = 16'(p);
    end else if (op == 4'd5) begin
      p = isqrt_ref(acc);
      r[63:48] = (p > 65535) ? 16'hFFFF : 16'(p);
    end
    return r;
  endfunction

  function automatic int busy_ref(input logic [3:0] op);
    if (op == OP_LENGTH) return 21;
    if (op == OP_MUL || op == OP_DOT || op == OP_SCALE) return 4;
    return 1;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [15:0] s, input logic [63:0] exp, input int busy);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.s = s; v.exp = exp; v.busy = 8'(busy);
    return v;
  endfunction

  // Caller is at posedge+1 with the engine idle.
  task automatic run_check(input string name, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [15:0] s,
                           input logic [63:0] exp, input int exp_busy);
    logic [63:0] prev;
    int          cyc, waited;
    bit          quiet;
    bus.start = 1'b1; bus.operation = op; bus.vec_a = a; bus.vec_b = b; bus.scalar = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.vec_a = {$urandom, $urandom}; bus.vec_b = {$urandom, $urandom}; bus.scalar = 16'($urandom);
    bus.operation = 4'($urandom);
    prev = bus.result; quiet = 1'b1; cyc = 0; waited = 0;
    while (!bus.done && waited < 60) begin
      if (bus.busy) cyc++;
      if (bus.result !== prev || bus.result_valid) quiet = 1'b0;
      waited++;
      @(posedge clk); #1;
    end
    check({name, " done"}, 64'(bus.done), 64'd1);
    check({name, " valid"}, 64'(bus.result_valid), 64'd1);
    check({name, " busy_cycles"}, 64'(cyc), 64'(exp_busy));
    check({name, " quiet_while_busy"}, 64'(quiet), 64'd1);
    check({name, " result"}, bus.result, exp);
    check({name, " busy_at_done"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check({name, " single_pulse"}, 64'(bus.done), 64'd0);
    check({name, " held"}, bus.result, exp);
  endtask

  initial begin : main
    int t1, waited, dones;
    logic [3:0] rop;
    logic [63:0] ra, rb, rexp;
    logic [15:0] rs;

    bus.start = 1'b0; bus.operation = '0; bus.vec_a = '0; bus.vec_b = '0; bus.scalar = '0;

    vt[0]  = mk(OP_SCALE,  64'hFF00_0000_0000_FF00, 64'h0, 16'h0080, 64'h7F80_0000_0000_7F80, 4);
    vt[1]  = mk(OP_SUB,    64'h0100_00C0_0000_0000, 64'h0080_007A_0000_0000, 16'h0, 64'h0080_0046_0000_0000, 1);
    vt[2]  = mk(OP_LENGTH, 64'h0030_0040_0000_0000, 64'h0, 16'h0, 64'h0050_0000_0000_0000, 21);
    vt[3]  = mk(OP_LENGTH, 64'hFFD0_FFC0_0000_0000, 64'h0, 16'h0, 64'h0050_0000_0000_0000, 21);
    vt[4]  = mk(OP_DOT,    64'h0100_0200_FF00_0000, 64'h0100_0100_0100_7FFF, 16'h0, 64'h0200_0000_0000_0000, 4);
    vt[5]  = mk(OP_DOT,    64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0, 64'h7FFF_0000_0000_0000, 4);
    vt[6]  = mk(OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4);
    vt[7]  = mk(4'hF,      64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 16'h55, 64'h0, 1);
    vt[8]  = mk(OP_ADD,    64'h0001_FFFF_8000_1234, 64'h0001_0001_8000_0001, 16'h0, 64'h0002_0000_0000_1235, 1);
    vt[9]  = mk(OP_MUL,    64'h0200_0080_0000_0100, 64'h0300_0080_1234_0100, 16'h0, 64'h0600_0040_0000_0100, 4);
    vt[10] = mk(OP_DOT,    64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0, 64'h8000_0000_0000_0000, 4);
    vt[11] = mk(OP_LENGTH, 64'h8000_8000_8000_8000, 64'h0, 16'h0, 64'hFFFF_0000_0000_0000, 21);

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset valid", 64'(bus.result_valid), 64'd0);
    check("reset result", bus.result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].s, vt[i].exp, int'(vt[i].busy));

    // start held high across a LENGTH op: requests while busy are dropped
    bus.start = 1'b1; bus.operation = OP_LENGTH; bus.vec_a = 64'h0030_0040_0000_0000; bus.vec_b = '0;
    @(posedge clk); #1;
    bus.operation = OP_ADD; bus.vec_a = 64'h0101_0101_0101_0101;
    t1 = 0; waited = 0;
    while (!bus.done && waited < 60) begin
      if (bus.busy) t1++;
      if (waited == 10) bus.start = 1'b0;
      waited++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("hold busy_cycles", 64'(t1), 64'd21);
    check("hold result", bus.result, 64'h0050_0000_0000_0000);
    @(posedge clk); #1;
    check("hold no_requeue", 64'(bus.busy), 64'd0);

    // back-to-back: second ADD issued in the FINISH cycle
    bus.start = 1'b1; bus.operation = OP_ADD; bus.vec_a = 64'h1; bus.vec_b = 64'h2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waited = 0;
    while (!bus.done && waited < 10) begin waited++; @(posedge clk); #1; end
    t1 = cycle;
    check("b2b first", bus.result, 64'h3);
    bus.start = 1'b1; bus.operation = OP_ADD; bus.vec_a = 64'h0010_0000_0000_0000; bus.vec_b = 64'h0020_0000_0000_0005;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b accepted", 64'(bus.busy), 64'd1);
    waited = 0;
    while (!bus.done && waited < 10) begin waited++; @(posedge clk); #1; end
    check("b2b gap", 64'(cycle - t1), 64'd2);
    check("b2b second", bus.result, 64'h0030_0000_0000_0005);
    @(posedge clk); #1;

    // reset during SQRT cycle 8
    bus.start = 1'b1; bus.operation = OP_LENGTH; bus.vec_a = 64'h0030_0040_0000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre-abort busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort result", bus.result, 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.done || bus.busy) dones++; end
    check("abort no_pulse", 64'(dones), 64'd0);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 6));
      if (rop == 4'd6) rop = 4'($urandom_range(6, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 16'($urandom);
      rexp = model(rop, ra, rb, rs);
      run_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rs, rexp, busy_ref(rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 500000", $time);
    $fatal(1);
  end

endmodule

// File: doc/vector_processor.md
Name: vector_processor

Overview:
- Responder end of the shader-to-vector-processor handshake.
- Accepts one vector operation per start pulse from the shader pipeline and computes it on 4-lane 8.8 fixed-point vectors.
- Returns the result with a one-cycle done/result_valid pulse.
- Multi-cycle engine: shares one multiplier across lanes and uses an iterative square root for LENGTH.

Parameters:
DATA_WIDTH, 16, lane width (8.8 fixed point)
VECTOR_WIDTH, 4, lanes per vector
SQRT_ITERS, 17, result bits produced by the restoring square root (one per cycle)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on an edge where start=1 and busy=0
operation  input  4  opcode, sampled on accept
vec_a  input  64  operand A; lane3=[63:48] ... lane0=[15:0]
vec_b  input  64  operand B
scalar  input  16  scalar operand (SCALE)
busy  output  1  engine occupied; registered
done  output  1  one-cycle completion pulse
result  output  64  result vector, held until the next completion
result_valid  output  1  one-cycle pulse, coincident with done

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: busy=0, done=0, result_valid=0, result=0, state=IDLE. Reset mid-operation aborts it; no pulse is emitted afterwards.
- Accept:
  - On an accepting edge, latch operation, vec_a, vec_b and scalar.
  - busy=1 from the next cycle.
  - start while busy=1 is ignored (not queued).
  - start in the same cycle as done=1 is accepted (back-to-back).
- States:
  - IDLE -> EXEC (ADD/SUB/illegal) or LANE (others).
  - EXEC -> FINISH after 1 cycle.
  - LANE steps lane 0..3, one lane per cycle -> FINISH (MUL/SCALE/DOT) or SQRT (LENGTH).
  - SQRT runs SQRT_ITERS cycles -> FINISH.
  - FINISH: result registered, done=result_valid=1, busy=0, -> IDLE. If start=1 in FINISH, go directly to EXEC/LANE.
- busy duration: ADD/SUB/illegal 1 cycle; MUL/SCALE/DOT 4 cycles; LENGTH 21 cycles. done rises on the same edge busy falls.
- Opcodes:
  - 0 ADD: per lane a+b, mod 2^16.
  - 1 SUB: per lane a-b, mod 2^16.
  - 2 MUL: per lane unsigned (a*b)>>8, saturate to 0xFFFF.
  - 3 DOT: signed sum of (a_i*b_i); 34-bit accumulator; arithmetic >>8; saturate to [0x8000,0x7FFF]; result in lane3, other lanes 0.
  - 4 SCALE: per lane unsigned (a_i*scalar)>>8, saturate to 0xFFFF.
  - 5 LENGTH: sum of signed squares a_i^2 (34-bit, Q16.16); floor integer sqrt gives Q8.8; saturate to 0xFFFF; result in lane3, other lanes 0.
  - 6..15 illegal: result=0, normal done pulse.
- Multiplier: one shared 17x17 signed multiplier. Unsigned ops zero-extend; signed ops sign-extend.
- No output changes while busy except busy itself. result is unchanged between completions.

Decomposition:
- Shared package vp_pkg: opcode constants OP_ADD..OP_LENGTH, FP_ONE=0x0100, lane index helpers, and the state encoding. The shader pipeline uses the same opcode constants.
- One sub-module: vp_isqrt. Restoring bit-serial square root with a start/done handshake; 34-bit radicand, 17-bit root, SQRT_ITERS cycles.

Test Plan:
- SCALE: vec_a={FF00,0000,0000,FF00}, scalar=0x0080 -> result={7F80,0000,0000,7F80}; busy 4 cycles; single done pulse.
- SUB: a={0100,00C0,0,0}, b={0080,007A,0,0} -> {0080,0046,0000,0000} after 1 busy cycle.
- LENGTH:
  - a={0030,0040,0,0} -> lane3=0x0050, lanes 2..0 = 0; busy 21 cycles.
  - a={FFD0,FFC0,0,0} -> same result.
- DOT / MUL saturation:
  - DOT a={0100,0200,FF00,0000}, b={0100,0100,0100,7FFF} -> lane3=0x0200.
  - DOT a=b={7FFF x4} -> lane3=0x7FFF.
  - MUL a=b={FFFF x4} -> {FFFF x4}.
- Handshake:
  - start held high during a LENGTH op: the second request is ignored.
  - start asserted in the FINISH cycle: back-to-back ADD accepted; its done arrives 2 cycles after the previous one.
  - opcode 0xF -> result 0, done after 1 busy cycle.
- Reset: rst_n asserted at SQRT cycle 8 -> busy=0 and result=0 immediately; no done pulse after release.
